// File: rtl/irrigation_controller_pkg.sv
// rtl/irrigation_controller_pkg.sv - shared state and moisture encodings for the irrigation controller
package irrigation_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SPRINKLE,
    ST_DRIP,
    ST_DONE
  } state_t;

  localparam logic [1:0] MOIST_DRY      = 2'b00;
  localparam logic [1:0] MOIST_MODERATE = 2'b01;
  localparam logic [1:0] MOIST_WET      = 2'b10;

  // Any code with the upper bit set reads as wet.
  function automatic logic is_wet(input logic [1:0] m);
    return m[1];
  endfunction

endpackage

// File: rtl/irrigation_controller_tick_sync.sv
// rtl/irrigation_controller_tick_sync.sv - 2-FF synchroniser plus rising-edge detect giving a one-cycle tick
module irrigation_controller_tick_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic tick_o
);

  logic s1_q, s2_q, s3_q;

  // Registers come out of reset high so a level already high at release is not an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick_o = s2_q & ~s3_q;

endmodule

// File: rtl/irrigation_controller.sv
// rtl/irrigation_controller.sv - fill/sprinkle/drip sequencer with tank level and irrigation timer
module irrigation_controller
  import irrigation_controller_pkg::*;
#(
  parameter int TANK_W      = 4,
  parameter int TANK_MAX    = 15,
  parameter int SPR_COST    = 2,
  parameter int IRR_SECONDS = 30,
  parameter int SEC_W       = 6
) (
  input  logic              clk_28hz,
  input  logic              rst_n,
  input  logic              clk_1hz,
  input  logic              fill_clk,
  input  logic              sprinkler_clk,
  input  logic              drip_clk,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        moisture,
  output logic              valve_fill,
  output logic              valve_spr,
  output logic              valve_drip,
  output logic [TANK_W-1:0] tank_level,
  output logic              busy,
  output logic              done
);

  localparam logic [TANK_W-1:0] TANK_FULL = TANK_W'(TANK_MAX);
  localparam logic [TANK_W-1:0] SPR_DEC   = TANK_W'(SPR_COST);
  localparam logic [SEC_W-1:0]  SEC_END   = SEC_W'(IRR_SECONDS);

  logic sec_tick, fill_tick, spr_tick, drip_tick;

  irrigation_controller_tick_sync u_sync_1hz  (.clk_i(clk_28hz), .rst_ni(rst_n), .async_i(clk_1hz),       .tick_o(sec_tick));
  irrigation_controller_tick_sync u_sync_fill (.clk_i(clk_28hz), .rst_ni(rst_n), .async_i(fill_clk),      .tick_o(fill_tick));
  irrigation_controller_tick_sync u_sync_spr  (.clk_i(clk_28hz), .rst_ni(rst_n), .async_i(sprinkler_clk), .tick_o(spr_tick));
  irrigation_controller_tick_sync u_sync_drip (.clk_i(clk_28hz), .rst_ni(rst_n), .async_i(drip_clk),      .tick_o(drip_tick));

  state_t              state_q, state_d;
  state_t              mode_q, mode_d;
  logic [TANK_W-1:0]   tank_q, tank_d;
  logic [SEC_W-1:0]    sec_q, sec_d;

  always_ff @(posedge clk_28hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= ST_SPRINKLE;
      tank_q  <= '0;
      sec_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tank_q  <= tank_d;
      sec_q   <= sec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tank_d  = tank_q;
    sec_d   = sec_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (is_wet(moisture)) begin
              state_d = ST_DONE;
            end else begin
              sec_d   = '0;
              mode_d  = (moisture == MOIST_DRY) ? ST_SPRINKLE : ST_DRIP;
              state_d = (tank_q < TANK_FULL) ? ST_FILL : mode_d;
            end
          end
        end
        ST_FILL: begin
          if (fill_tick && (tank_q < TANK_FULL)) tank_d = tank_q + 1'b1;
          if (tank_d == TANK_FULL) state_d = mode_q;
        end
        ST_SPRINKLE, ST_DRIP: begin
          if ((state_q == ST_SPRINKLE) && spr_tick)
            tank_d = (tank_q >= SPR_DEC) ? tank_q - SPR_DEC : '0;
          if ((state_q == ST_DRIP) && drip_tick)
            tank_d = (tank_q != '0) ? tank_q - 1'b1 : '0;
          if (sec_tick) sec_d = sec_q + 1'b1;
          // Exit tests look at this cycle's updated tank and seconds.
          if (is_wet(moisture))      state_d = ST_DONE;
          else if (sec_d == SEC_END) state_d = ST_DONE;
          else if (tank_d == '0)     state_d = ST_FILL;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign valve_fill = (state_q == ST_FILL);
  assign valve_spr  = (state_q == ST_SPRINKLE);
  assign valve_drip = (state_q == ST_DRIP);
  assign tank_level = tank_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

endmodule
